// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and hands {inst, inst_pc} to decode.
// Optional performance counters are enabled with `define IFU_FETCH_PERF_EN.
module ifu_fetch #(
  parameter int unsigned        INST_W   = 32,
  parameter logic [INST_W-1:0]  RESET_PC = 32'h80000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [INST_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] inst_pc,
  output logic              inst_fault,
`ifdef IFU_FETCH_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  input  logic              redirect_valid,
  input  logic [INST_W-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state;
  logic [INST_W-1:0] pc;
  logic              kill;
  logic [INST_W-1:0] pc_next_c;
  logic              pc_next_aligned_c;

  // Redirect beats the sequential increment, which only happens on a HOLD consume.
  always_comb begin
    pc_next_c = pc;
    if (redirect_valid) begin
      pc_next_c = redirect_pc;
    end else if (state == HOLD && inst_ready) begin
      pc_next_c = pc + INST_W'(4);
    end
    pc_next_aligned_c = (pc_next_c[1:0] == 2'b00);
  end

  assign imem_req_addr = pc;

  // imem_req_valid is registered from the PC that REQ will present, so a misaligned PC never issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      kill           <= 1'b0;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst           <= '0;
      inst_pc        <= '0;
      inst_fault     <= 1'b0;
    end else begin
      pc             <= pc_next_c;
      imem_req_valid <= 1'b0;
      case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= pc_next_aligned_c;
        end
        REQ: begin
          if (imem_req_valid && imem_req_ready) begin
            state <= WAIT;
            kill  <= redirect_valid;
          end else if (redirect_valid) begin
            imem_req_valid <= pc_next_aligned_c;
          end else if (pc[1:0] != 2'b00) begin
            state      <= HOLD;
            inst       <= '0;
            inst_pc    <= pc;
            inst_fault <= 1'b1;
            inst_valid <= 1'b1;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            kill <= 1'b0;
            if (kill || redirect_valid) begin
              state          <= REQ;
              imem_req_valid <= pc_next_aligned_c;
            end else begin
              state      <= HOLD;
              inst       <= imem_rsp_err ? '0 : imem_rsp_data;
              inst_pc    <= pc;
              inst_fault <= imem_rsp_err;
              inst_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || inst_ready) begin
            state          <= REQ;
            inst_valid     <= 1'b0;
            imem_req_valid <= pc_next_aligned_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFU_FETCH_PERF_EN
  // Retired-to-decode handshakes and cycles spent waiting on instruction memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (inst_valid && inst_ready) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (state == WAIT || (state == REQ && imem_req_valid && !imem_req_ready)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: per-cycle vector table plus reset/latency sequences.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFU_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
`ifdef IFU_FETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        irdy;
    logic        qrdy;
    logic        rv;
    logic [31:0] rdata;
    logic        rerr;
    logic        e_qv;
    logic [31:0] e_qaddr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic irdy,
                              input logic qrdy, input logic rv, input logic [31:0] rdata,
                              input logic rerr, input logic e_qv, input logic [31:0] e_qaddr,
                              input logic e_iv, input logic [31:0] e_inst,
                              input logic [31:0] e_ipc, input logic e_flt);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.irdy = irdy; v.qrdy = qrdy; v.rv = rv;
    v.rdata = rdata; v.rerr = rerr; v.e_qv = e_qv; v.e_qaddr = e_qaddr;
    v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_flt = e_flt;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive_idle();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: redir rpc irdy qrdy rv rdata rerr | qv qaddr iv inst ipc flt
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h80000000, 0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 1,32'h80000000, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h11111111,0, 0,32'h80000000, 0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,32'h80000000, 1,32'h11111111,32'h80000000,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 1,32'h80000004, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h22222222,0, 0,32'h80000004, 0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,32'h80000004, 1,32'h22222222,32'h80000004,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 1,32'h80000008, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h33333333,0, 0,32'h80000008, 0,0,0,0));
    // Decode stalls five cycles; a stray response in HOLD is ignored.
    vecs.push_back(mk(0,0,0,1,1,32'hBADBADBA,0, 0,32'h80000008, 1,32'h33333333,32'h80000008,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,0,1,0,0,0, 0,32'h80000008, 1,32'h33333333,32'h80000008,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,32'h80000008, 1,32'h33333333,32'h80000008,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,32'h8000000C, 0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 1,32'h8000000C, 0,0,0,0));
    // Redirect in WAIT: the following response must be dropped.
    vecs.push_back(mk(1,32'h80000100,0,0,0,0,0, 0,32'h8000000C, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h00000013,0, 0,32'h80000100, 0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 1,32'h80000100, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h44444444,0, 0,32'h80000100, 0,0,0,0));
    // Redirect in HOLD to a misaligned target: no request, fault slot instead.
    vecs.push_back(mk(1,32'h80000202,0,0,0,0,0, 0,32'h80000100, 1,32'h44444444,32'h80000100,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 0,32'h80000202, 0,0,0,0));
    vecs.push_back(mk(1,32'h80000010,1,0,0,0,0, 0,32'h80000202, 1,0,32'h80000202,1));
    vecs.push_back(mk(0,0,0,1,0,0,0, 1,32'h80000010, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'hDEADBEEF,1, 0,32'h80000010, 0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,32'h80000010, 1,0,32'h80000010,1));
    // Redirect in REQ without handshake moves the address.
    vecs.push_back(mk(1,32'hFFFFFFFC,0,0,0,0,0, 1,32'h80000014, 0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 1,32'hFFFFFFFC, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h55555555,0, 0,32'hFFFFFFFC, 0,0,0,0));
    // Redirect and consume together at FFFFFFFC: redirect wins.
    vecs.push_back(mk(1,32'h80000400,1,0,0,0,0, 0,32'hFFFFFFFC, 1,32'h55555555,32'hFFFFFFFC,0));
    vecs.push_back(mk(1,32'hFFFFFFFC,0,0,0,0,0, 1,32'h80000400, 0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 1,32'hFFFFFFFC, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h66666666,0, 0,32'hFFFFFFFC, 0,0,0,0));
    // Plain consume at FFFFFFFC wraps to zero.
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,32'hFFFFFFFC, 1,32'h66666666,32'hFFFFFFFC,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 1,32'h00000000, 0,0,0,0));
    // Redirect coinciding with the response in WAIT drops it.
    vecs.push_back(mk(1,32'h80000800,0,0,1,32'h77777777,0, 0,32'h00000000, 0,0,0,0));
    // Redirect coinciding with the request handshake kills that fetch.
    vecs.push_back(mk(1,32'h80000900,0,1,0,0,0, 1,32'h80000800, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h88888888,0, 0,32'h80000900, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,32'h80000900, 0,0,0,0));

    do_reset();
    @(negedge clk);
    chk("rst_req_valid", -1, 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr",  -1, imem_req_addr, 32'h80000000);
    chk("rst_inst_valid",-1, 32'(inst_valid), 32'd0);
    chk("rst_inst",      -1, inst, 32'd0);
    chk("rst_inst_pc",   -1, inst_pc, 32'd0);
    chk("rst_inst_fault",-1, 32'(inst_fault), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      inst_ready     = vecs[i].irdy;
      imem_req_ready = vecs[i].qrdy;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data  = vecs[i].rdata;
      imem_rsp_err   = vecs[i].rerr;
      @(negedge clk);
      chk("req_valid",  i, 32'(imem_req_valid), 32'(vecs[i].e_qv));
      chk("req_addr",   i, imem_req_addr, vecs[i].e_qaddr);
      chk("inst_valid", i, 32'(inst_valid), 32'(vecs[i].e_iv));
      if (vecs[i].e_iv) begin
        chk("inst",       i, inst, vecs[i].e_inst);
        chk("inst_pc",    i, inst_pc, vecs[i].e_ipc);
        chk("inst_fault", i, 32'(inst_fault), 32'(vecs[i].e_flt));
      end
      @(posedge clk);
      #1;
    end

    // Mid-operation reset while WAIT has a killed fetch pending, then latency from reset.
    drive_idle();
    imem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80001000;
    imem_req_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_valid", -2, 32'(imem_req_valid), 32'd0);
    chk("mid_rst_inst_valid",-2, 32'(inst_valid), 32'd0);
    chk("mid_rst_req_addr",  -2, imem_req_addr, 32'h80000000);
    begin
      int  cyc;
      bit  seen;
      bit  pend;
      seen = 1'b0;
      pend = 1'b0;
      cyc  = 0;
      imem_req_ready = 1'b1;
      for (int n = 0; n < 20 && !seen; n++) begin
        if (inst_valid) begin
          seen = 1'b1;
          cyc  = n;
        end else begin
          @(posedge clk);
          pend = imem_req_valid && imem_req_ready;
          #1;
          imem_rsp_valid = pend;
          imem_rsp_data  = 32'hA5A5A5A5;
          @(negedge clk);
        end
      end
      chk("lat_seen", -3, 32'(seen), 32'd1);
      chk("lat_cycles", -3, 32'(cyc), 32'd3);
      chk("lat_inst", -3, inst, 32'hA5A5A5A5);
      chk("lat_inst_pc", -3, inst_pc, 32'h80000000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
